// File: rtl/quantized_maxpool2d.sv
// Streaming 2x2 stride-2 max-pool of a channel-major 8-bit conv stream, emitting padded-RAM write addresses.
// Latency: out_valid one cycle after the beat that completes a 2x2 window.
// Backpressure: none; every in_valid beat in RUN is consumed and the sink must accept every out_valid strobe.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   start                one-cycle pulse; (re)arms the block for a new frame
//   in_data/in_valid     unsigned pixel beats from the conv stage (gaps allowed)
//   out_data/out_valid   pooled max value and its one-cycle write strobe
//   out_addr             ch*PH*PW + (prow+PAD)*PW + (pcol+PAD) in the next layer's padded map
//   busy                 high while a frame is being consumed
//   done                 high after the final pooled value, held until the next start
module quantized_maxpool2d #(
  parameter  int CHANNELS  = 32,
  parameter  int IN_WIDTH  = 28,
  parameter  int IN_HEIGHT = 28,
  parameter  int PAD       = 1,
  localparam int OUT_W     = IN_WIDTH / 2,
  localparam int OUT_H     = IN_HEIGHT / 2,
  localparam int PW        = OUT_W + 2 * PAD,
  localparam int PH        = OUT_H + 2 * PAD,
  localparam int AW        = $clog2(CHANNELS * PH * PW)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic [7:0]    out_data,
  output logic          out_valid,
  output logic [AW-1:0] out_addr,
  output logic          busy,
  output logic          done
);

  localparam int CW  = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
  localparam int RW  = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam int CHW = (CHANNELS  > 1) ? $clog2(CHANNELS)  : 1;
  localparam int LBW = (OUT_W     > 1) ? $clog2(OUT_W)     : 1;

  localparam logic [CW-1:0]  COL_LAST = CW'(IN_WIDTH - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(IN_HEIGHT - 1);
  localparam logic [CHW-1:0] CH_LAST  = CHW'(CHANNELS - 1);
  // With an odd height the last row has no partner row and is skipped.
  // An odd width needs no equivalent: its trailing column is even, so it
  // only ever loads hreg and never completes a window.
  localparam bit             H_ODD    = (IN_HEIGHT % 2) != 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state;
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [CHW-1:0] ch;
  logic [7:0]     hreg;
  logic [7:0]     linebuf [OUT_W];

  logic [7:0]     m;
  logic [7:0]     lb_rd;
  logic [7:0]     pooled;
  logic [LBW-1:0] pcol;
  logic [RW-1:0]  prow;
  logic           row_pool;
  logic           last_beat;
  logic [AW-1:0]  addr_next;

  always_comb begin
    pcol      = LBW'(col >> 1);
    prow      = row >> 1;
    m         = (in_data > hreg) ? in_data : hreg;
    lb_rd     = linebuf[pcol];
    pooled    = (lb_rd > m) ? lb_rd : m;
    row_pool  = !(H_ODD && (row == ROW_LAST));
    last_beat = (col == COL_LAST) && (row == ROW_LAST) && (ch == CH_LAST);
    addr_next = AW'(32'(ch) * 32'(PH * PW)
                    + (32'(prow) + 32'(PAD)) * 32'(PW)
                    + 32'(pcol) + 32'(PAD));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      col       <= '0;
      row       <= '0;
      ch        <= '0;
      hreg      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < OUT_W; i++) begin
        linebuf[i] <= 8'h00;
      end
    end else begin
      out_valid <= 1'b0;
      if (start) begin
        // Restart from any state; a beat arriving with start is dropped and
        // any partial maxima are simply overwritten by the new frame.
        state <= S_RUN;
        col   <= '0;
        row   <= '0;
        ch    <= '0;
        hreg  <= '0;
        busy  <= 1'b1;
        done  <= 1'b0;
      end else if (state == S_RUN && in_valid) begin
        if (col == COL_LAST) begin
          col <= '0;
          if (row == ROW_LAST) begin
            row <= '0;
            ch  <= ch + CHW'(1);
          end else begin
            row <= row + RW'(1);
          end
        end else begin
          col <= col + CW'(1);
        end

        if (!col[0]) begin
          hreg <= in_data;
        end else if (row_pool) begin
          // Even rows park the horizontal max; the odd row below finishes
          // the window, so the entry is always rewritten before its next read.
          if (!row[0]) begin
            linebuf[pcol] <= m;
          end else begin
            out_data  <= pooled;
            out_addr  <= addr_next;
            out_valid <= 1'b1;
          end
        end

        if (last_beat) begin
          state <= S_DONE;
          ch    <= '0;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/quantized_maxpool2d.md
Name: quantized_maxpool2d

Overview:
- Streaming 2x2, stride-2 max-pooling stage directly downstream of the quantized conv+ReLU layer.
- Consumes the conv's 8-bit unsigned output stream (conv_result/conv_valid). The stream is ordered channel-major, then row-major over IN_HEIGHT x IN_WIDTH.
- Emits pooled bytes, each with a write address into the zero-padded input feature-map RAM of the next conv layer, so the output drives that RAM's data/we/addr write port directly.

Parameters:
- CHANNELS, 32, number of feature-map channels in the stream.
- IN_WIDTH, 28, conv output width (pixels per row).
- IN_HEIGHT, 28, conv output height (rows per channel).
- PAD, 1, zero-pad border of the next layer's input map; affects addressing only.
- Derived, not overridable: OUT_W = IN_WIDTH/2 (floor), OUT_H = IN_HEIGHT/2 (floor), PW = OUT_W+2*PAD, PH = OUT_H+2*PAD, AW = $clog2(CHANNELS*PH*PW).

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- start  in  1  one-cycle pulse; arms block for a new frame
- in_data  in  8  unsigned pixel from the conv stage
- in_valid  in  1  in_data is valid this cycle (single-cycle beats, arbitrary gaps allowed)
- out_data  out  8  pooled max value
- out_valid  out  1  one-cycle write strobe for out_data/out_addr
- out_addr  out  AW  ch*PH*PW + (prow+PAD)*PW + (pcol+PAD)
- busy  out  1  high in RUN
- done  out  1  high after the final pooled value; held until the next start

Behaviour:
- Interface: one clock, clk. Reset rstn is asynchronous, active-low. Reset forces all outputs to 0, state to IDLE, and clears all counters and holding registers, regardless of any frame in progress.
- States and transitions:
  - IDLE: waits for start.
  - IDLE/DONE -> RUN on start. Entering RUN clears col, row, ch and done; busy goes to 1.
  - RUN -> DONE on the beat where ch=CHANNELS-1, row=IN_HEIGHT-1, col=IN_WIDTH-1. busy goes to 0 and done goes to 1 on the next edge.
  - DONE holds until start.
  - start during RUN restarts the frame: counters are cleared and partial maxima are discarded.
- in_valid outside RUN is ignored. If start and in_valid occur in the same cycle, start wins and the beat is dropped.
- Counters advance only on in_valid beats in RUN:
  - col wraps at IN_WIDTH-1 and increments row.
  - row wraps at IN_HEIGHT-1 and increments ch.
- Datapath (all compares unsigned 8-bit):
  - Even col: hreg <= in_data.
  - Odd col: m = max(hreg, in_data).
  - Odd col, even row: linebuf[col>>1] <= m. linebuf depth is OUT_W x 8 bits.
  - Odd col, odd row: out_data <= max(linebuf[col>>1], m), out_addr computed from ch, prow=row>>1, pcol=col>>1, and out_valid <= 1 for exactly one cycle.
- Latency: out_valid rises on the edge after the beat that completes the 2x2 window, i.e. 1 cycle.
- Odd dimensions: a trailing odd column (col=IN_WIDTH-1 with IN_WIDTH odd) or trailing odd row is counted for wrap purposes but never pooled or emitted.
- Output count per frame is exactly CHANNELS*OUT_H*OUT_W.
- Emitted addresses are strictly increasing within a frame. Padding addresses are never written; the next layer's RAM is pre-zeroed elsewhere.
- The final out_valid and the done rising edge occur on the same clock edge.
- Linebuf needs no clearing between rows or channels: every even row fully overwrites the entries read on the following odd row.

Test Plan:
- Basic pooling (CHANNELS=2, IN_WIDTH=4, IN_HEIGHT=4, PAD=1): start, then 32 back-to-back beats. Channel 0 is 0..15, channel 1 is 100..115.
  - Expected outputs as (value@address): 5@5, 7@6, 13@9, 15@10, 105@21, 107@22, 113@25, 115@26.
  - done=1 on the same edge as the last out_valid; busy=0 afterwards.
- Odd dimensions (IN_WIDTH=5, IN_HEIGHT=5, CHANNELS=1, PAD=0): pixel = row*5+col. Outputs: 6@0, 8@1, 16@2, 18@3 only. Column 4 and row 4 produce no out_valid; done after beat 25.
- Bubbles: repeat the basic-pooling stream with in_valid low for 0-3 random cycles between beats. Values and addresses are identical; each out_valid is still exactly 1 cycle after the completing beat.
- Unsigned extremes: window {255,0,0,254} -> 255. Window {0,0,0,0} -> 0. Window {128,127,1,129} -> 129.
- Control:
  - in_valid beats before start produce no outputs.
  - start asserted together with a beat drops that beat.
  - start mid-frame (after 7 beats), then a full clean frame, yields only the clean frame's 8 outputs.
  - A second start in DONE clears done the next cycle.
- Reset mid-frame: deassert rstn after 10 beats. out_valid, done, busy, out_data and out_addr read 0 immediately. A subsequent start plus a full frame gives the basic-pooling expected output exactly.
